seq_counter_gen: RTL and testbench
==================================

Name: seq_counter_gen

Overview:
Parametrised sequence counter for the control unit timing chain. It generates the step number and one-hot timing signals T0..Tn that drive the control decoder. Compared with the fixed 3-bit counter, it adds a configurable width and terminal step, a synchronous clear from control logic, parallel load, a wrap or saturate mode, terminal-count and wrap indications, and load-range checking.

Parameters:
WIDTH, 4, bit width of the step number; must be at least 1.
MAX_COUNT, 7, terminal step; legal range 1 to 2**WIDTH-1.
WRAP, 1, 1 = wrap MAX_COUNT->0 on inc; 0 = saturate at MAX_COUNT.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous active-high reset.
clr  input  1  synchronous clear from control logic (end of instruction).
inc  input  1  advance one step.
load  input  1  parallel load of load_value.
load_value  input  WIDTH  value to load.
number  output  WIDTH  current step, registered.
t_onehot  output  MAX_COUNT+1  timing signals; bit k=1 iff number==k; combinational from number.
tc  output  1  terminal count, number==MAX_COUNT; combinational.
wrapped  output  1  registered one-cycle pulse after a MAX_COUNT->0 wrap.
load_err  output  1  registered one-cycle pulse after an out-of-range load.

Behaviour:
- All state updates happen on the rising edge of clk. No asynchronous paths.
- Priority per edge, highest first: reset > clr > load > inc > hold.
- reset=1:
  - number=0, wrapped=0, load_err=0.
  - Hence t_onehot=1 (T0 asserted) and tc=0.
- clr=1 (reset=0):
  - number=0; wrapped=0; load_err=0.
  - load and inc are ignored that cycle.
- load=1 (no reset/clr):
  - If load_value<=MAX_COUNT: number=load_value, load_err=0.
  - If load_value>MAX_COUNT: number=MAX_COUNT, load_err=1 for exactly the next cycle.
  - inc is ignored; wrapped=0.
- inc=1 alone:
  - If number<MAX_COUNT: number=number+1, wrapped=0.
  - If number==MAX_COUNT and WRAP=1: number=0, wrapped=1 for one cycle.
  - If number==MAX_COUNT and WRAP=0: number stays at MAX_COUNT, wrapped=0.
- No control active: number holds; wrapped=0 and load_err=0.
- Arithmetic:
  - Increment is modulo 2**WIDTH but never exceeds MAX_COUNT.
  - When MAX_COUNT=2**WIDTH-1, the wrap is the natural overflow.
  - No intermediate value above MAX_COUNT is ever visible on number.
- t_onehot:
  - Exactly one bit is set at all times after the first reset.
  - Values above MAX_COUNT are unreachable, so no bit is undefined.
- Reset mid-operation: any step, pending pulse or load is discarded; T0 asserts on the next cycle.
- Elaboration check: a parameter set violating MAX_COUNT<2**WIDTH or MAX_COUNT>=1 must cause a simulation $error.

Optional Feature:
Macro SC_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - hold=1 freezes number and forces wrapped=0 and load_err=0 (memory-wait stall).
  - hold ranks below reset and clr and above load and inc.
- Not defined:
  - No hold port.
  - Behaviour is exactly as described above.

Test Plan:
1. WIDTH=3, MAX_COUNT=7, WRAP=1: reset=1 for 1 cycle, then inc=1 for 9 cycles -> number 0,1,..,7,0,1; t_onehot=8'h01 after reset; tc=1 only at 7; wrapped=1 exactly one cycle, in the cycle number=0.
2. MAX_COUNT=5, WRAP=0: inc held 8 cycles from 0 -> number 1..5 then stays 5; tc=1 from step 5 on; wrapped never asserts.
3. WIDTH=4, MAX_COUNT=9: load=1 with load_value=12 -> number=9, load_err=1 for one cycle; then load_value=3 -> number=3, load_err=0.
4. number=4 with clr=1, load=1 and inc=1 in the same cycle -> number=0; then reset=1 together with inc=1 -> number=0, t_onehot bit0 only.
5. Counting at number=6 (MAX_COUNT=7): assert reset mid-sequence -> next cycle number=0, wrapped=0, load_err=0; inc resumes from 1.
6. With SC_HOLD_EN, number=3: hold=1 and inc=1 for 3 cycles -> number stays 3; release hold -> 4; hold=1 with clr=1 -> number=0.

Source files
------------

// File: rtl/seq_counter_gen.sv
// rtl/seq_counter_gen.sv - parametrised step counter with one-hot timing outputs T0..Tn
// Optional macro SC_HOLD_EN adds a hold (stall) input ranked below reset/clr and above load/inc.
module seq_counter_gen #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 7,
    parameter int WRAP      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
`ifdef SC_HOLD_EN
    input  logic                 hold,
`endif
    output logic [WIDTH-1:0]     number,
    output logic [MAX_COUNT:0]   t_onehot,
    output logic                 tc,
    output logic                 wrapped,
    output logic                 load_err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    if (WIDTH < 1 || MAX_COUNT < 1 || 64'(MAX_COUNT) >= (64'd1 << WIDTH)) begin : g_param_check
        $error("seq_counter_gen: illegal parameters WIDTH=%0d MAX_COUNT=%0d", WIDTH, MAX_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            number   <= '0;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            number   <= '0;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
`ifdef SC_HOLD_EN
        end else if (hold) begin
            wrapped  <= 1'b0;
            load_err <= 1'b0;
`endif
        end else if (load) begin
            wrapped <= 1'b0;
            // Out-of-range loads clamp to the terminal step so number never leaves 0..MAX_COUNT.
            if (load_value > MAX_V) begin
                number   <= MAX_V;
                load_err <= 1'b1;
            end else begin
                number   <= load_value;
                load_err <= 1'b0;
            end
        end else if (inc) begin
            load_err <= 1'b0;
            if (number < MAX_V) begin
                number  <= number + WIDTH'(1);
                wrapped <= 1'b0;
            end else if (WRAP != 0) begin
                number  <= '0;
                wrapped <= 1'b1;
            end else begin
                wrapped <= 1'b0;
            end
        end else begin
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end
    end

    always_comb begin
        t_onehot = '0;
        for (int k = 0; k <= MAX_COUNT; k++) begin
            t_onehot[k] = (number == WIDTH'(k));
        end
    end

    assign tc = (number == MAX_V);

endmodule

// File: tb/tb_seq_counter_gen.sv
// tb/tb_seq_counter_gen.sv - directed self-checking bench for seq_counter_gen
module tb_seq_counter_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       inc = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;
`ifdef SC_HOLD_EN
    logic       hold = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // a: WIDTH=3 MAX=7 WRAP=1, b: WIDTH=3 MAX=5 WRAP=0, c: WIDTH=4 MAX=9 WRAP=1
    logic [2:0] a_num, b_num;
    logic [3:0] c_num;
    logic [7:0] a_oh;
    logic [5:0] b_oh;
    logic [9:0] c_oh;
    logic a_tc, a_wr, a_le, b_tc, b_wr, b_le, c_tc, c_wr, c_le;

    always #5 clk = ~clk;

    seq_counter_gen #(.WIDTH(3), .MAX_COUNT(7), .WRAP(1)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .inc(inc), .load(load), .load_value(lv[2:0]),
`ifdef SC_HOLD_EN
        .hold(hold),
`endif
        .number(a_num), .t_onehot(a_oh), .tc(a_tc), .wrapped(a_wr), .load_err(a_le));

    seq_counter_gen #(.WIDTH(3), .MAX_COUNT(5), .WRAP(0)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .inc(inc), .load(load), .load_value(lv[2:0]),
`ifdef SC_HOLD_EN
        .hold(hold),
`endif
        .number(b_num), .t_onehot(b_oh), .tc(b_tc), .wrapped(b_wr), .load_err(b_le));

    seq_counter_gen #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .inc(inc), .load(load), .load_value(lv),
`ifdef SC_HOLD_EN
        .hold(hold),
`endif
        .number(c_num), .t_onehot(c_oh), .tc(c_tc), .wrapped(c_wr), .load_err(c_le));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clr = 1'b0; inc = 1'b0; load = 1'b0; lv = 4'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inc = 1'b1;
        tick();
        reset = 1'b0; inc = 1'b0;
        checks++; if (a_num !== 3'd0) begin errors++; $display("FAIL reset_num got %0d exp 0", a_num); end
        checks++; if (a_oh !== 8'h01) begin errors++; $display("FAIL reset_onehot got %h exp 01", a_oh); end
        checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", a_tc); end
        checks++; if ({a_wr, a_le} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {a_wr, a_le}); end
        checks++; if (c_oh !== 10'h001) begin errors++; $display("FAIL reset_onehot_c got %h exp 001", c_oh); end
    endtask

    task automatic test_wrap();
        int exp_n [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        logic [7:0] exp_oh;
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_oh = 8'b1 << exp_n[i];
            checks++; if (a_num !== 3'(exp_n[i])) begin errors++; $display("FAIL wrap_num[%0d] got %0d exp %0d", i, a_num, exp_n[i]); end
            checks++; if (a_oh !== exp_oh) begin errors++; $display("FAIL wrap_onehot[%0d] got %h exp %h", i, a_oh, exp_oh); end
            checks++; if (a_tc !== (exp_n[i] == 7)) begin errors++; $display("FAIL wrap_tc[%0d] got %b", i, a_tc); end
            checks++; if (a_wr !== (i == 7)) begin errors++; $display("FAIL wrap_pulse[%0d] got %b exp %b", i, a_wr, (i == 7)); end
        end
        inc = 1'b0;
    endtask

    task automatic test_saturate();
        int e;
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = (i + 1 > 5) ? 5 : i + 1;
            checks++; if (b_num !== 3'(e)) begin errors++; $display("FAIL sat_num[%0d] got %0d exp %0d", i, b_num, e); end
            checks++; if (b_tc !== (e == 5)) begin errors++; $display("FAIL sat_tc[%0d] got %b", i, b_tc); end
            checks++; if (b_wr !== 1'b0) begin errors++; $display("FAIL sat_wrapped[%0d] got %b exp 0", i, b_wr); end
        end
        inc = 1'b0;
    endtask

    task automatic test_load();
        do_reset();
        load = 1'b1; lv = 4'd12;
        tick();
        checks++; if (c_num !== 4'd9) begin errors++; $display("FAIL load_clamp got %0d exp 9", c_num); end
        checks++; if (c_le !== 1'b1) begin errors++; $display("FAIL load_err_set got %b exp 1", c_le); end
        checks++; if (c_tc !== 1'b1) begin errors++; $display("FAIL load_clamp_tc got %b exp 1", c_tc); end
        lv = 4'd3;
        tick();
        checks++; if (c_num !== 4'd3) begin errors++; $display("FAIL load_ok got %0d exp 3", c_num); end
        checks++; if (c_le !== 1'b0) begin errors++; $display("FAIL load_err_clear got %b exp 0", c_le); end
        lv = 4'd9;
        tick();
        checks++; if ({c_num, c_le} !== {4'd9, 1'b0}) begin errors++; $display("FAIL load_boundary got %0d/%b exp 9/0", c_num, c_le); end
        lv = 4'd10;
        tick();
        load = 1'b0;
        tick();
        checks++; if ({c_num, c_le} !== {4'd9, 1'b0}) begin errors++; $display("FAIL load_err_one_cycle got %0d/%b exp 9/0", c_num, c_le); end
        load = 1'b1; inc = 1'b1; lv = 4'd2;
        tick();
        load = 1'b0; inc = 1'b0;
        checks++; if (c_num !== 4'd2) begin errors++; $display("FAIL load_over_inc got %0d exp 2", c_num); end
    endtask

    task automatic test_priority();
        do_reset();
        load = 1'b1; lv = 4'd4;
        tick();
        clr = 1'b1; load = 1'b1; inc = 1'b1; lv = 4'd7;
        tick();
        clr = 1'b0; load = 1'b0;
        checks++; if ({c_num, c_wr, c_le} !== 6'd0) begin errors++; $display("FAIL clr_priority got %0d/%b/%b exp 0/0/0", c_num, c_wr, c_le); end
        tick();
        checks++; if (c_num !== 4'd1) begin errors++; $display("FAIL inc_after_clr got %0d exp 1", c_num); end
        reset = 1'b1;
        tick();
        reset = 1'b0; inc = 1'b0;
        checks++; if (c_num !== 4'd0 || c_oh !== 10'h001) begin errors++; $display("FAIL reset_over_inc got %0d/%h exp 0/001", c_num, c_oh); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (a_num !== 3'd6) begin errors++; $display("FAIL mid_setup got %0d exp 6", a_num); end
        reset = 1'b1; load = 1'b1; lv = 4'd15;
        tick();
        reset = 1'b0; load = 1'b0;
        checks++; if ({a_num, a_wr, a_le} !== 5'd0) begin errors++; $display("FAIL mid_reset got %0d/%b/%b exp 0/0/0", a_num, a_wr, a_le); end
        checks++; if ({c_num, c_le} !== 5'd0) begin errors++; $display("FAIL mid_reset_load got %0d/%b exp 0/0", c_num, c_le); end
        tick();
        inc = 1'b0;
        checks++; if (a_num !== 3'd1) begin errors++; $display("FAIL mid_resume got %0d exp 1", a_num); end
    endtask

`ifdef SC_HOLD_EN
    task automatic test_hold();
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_num !== 3'd3) begin errors++; $display("FAIL hold_freeze[%0d] got %0d exp 3", i, a_num); end
        end
        hold = 1'b0;
        tick();
        checks++; if (a_num !== 3'd4) begin errors++; $display("FAIL hold_release got %0d exp 4", a_num); end
        hold = 1'b1; clr = 1'b1;
        tick();
        hold = 1'b0; clr = 1'b0; inc = 1'b0;
        checks++; if (a_num !== 3'd0) begin errors++; $display("FAIL hold_clr got %0d exp 0", a_num); end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_wrap();
        test_saturate();
        test_load();
        test_priority();
        test_mid_reset();
`ifdef SC_HOLD_EN
        test_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
